// File: rtl/bridge_gate_drv_pkg.sv
// Shared encodings and defaults for the H-bridge gate-drive stage.
package bridge_gate_drv_pkg;

  localparam int DT_W_DEF     = 4;
  localparam int DT_RESET_DEF = 2;
  localparam int FC_W_DEF     = 8;

  // One-hot state encoding; gate outputs are taken straight from these bits.
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_DRV_A = 5'b00010,
    S_DRV_B = 5'b00100,
    S_DEAD  = 5'b01000,
    S_FAULT = 5'b10000
  } state_e;

  localparam int IDX_DRV_A = 1;
  localparam int IDX_DRV_B = 2;
  localparam int IDX_FAULT = 4;

  // Request decode of {forward, back} after the input register.
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_B    = 2'b01,
    REQ_A    = 2'b10,
    REQ_ILL  = 2'b11
  } req_e;

endpackage

// File: rtl/bridge_gate_drv_dead_timer.sv
// Dead-time register and down-counter; expire_o marks the last cycle of a DEAD interval.
module bridge_gate_drv_dead_timer #(
  parameter int DT_W     = 4,
  parameter int DT_RESET = 2
) (
  input  logic            clkin,
  input  logic            resetn,
  input  logic            load_i,
  input  logic [DT_W-1:0] dtdata_i,
  input  logic            start_i,
  output logic            expire_o
);

  logic [DT_W-1:0] dt_q, dt_d;
  logic [DT_W-1:0] dcnt_q, dcnt_d;

  // A zero dead time still yields one all-off cycle; start uses the value held before any same-cycle load.
  always_comb begin
    dt_d   = dt_q;
    dcnt_d = dcnt_q;
    if (load_i) dt_d = dtdata_i;
    if (start_i) begin
      dcnt_d = (dt_q == '0) ? DT_W'(1) : dt_q;
    end else if (dcnt_q != '0) begin
      dcnt_d = dcnt_q - DT_W'(1);
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      dt_q   <= DT_W'(DT_RESET);
      dcnt_q <= '0;
    end else begin
      dt_q   <= dt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign expire_o = (dcnt_q == DT_W'(1));

endmodule

// File: rtl/bridge_gate_drv.sv
// Gate-drive stage: turns forward/back/dumpoff requests into dead-time separated
// half-bridge gate signals, latching and counting shoot-through faults.
module bridge_gate_drv
  import bridge_gate_drv_pkg::*;
#(
  parameter int DT_W     = DT_W_DEF,
  parameter int DT_RESET = DT_RESET_DEF,
  parameter int FC_W     = FC_W_DEF
) (
  input  logic            clkin,
  input  logic            resetn,
  input  logic            forward,
  input  logic            back,
  input  logic            dumpoff_ctrl,
  input  logic            load,
  input  logic [DT_W-1:0] dtdata,
  input  logic            clr_fault,
  output logic            ha,
  output logic            lb,
  output logic            hb,
  output logic            la,
  output logic            dump_gate,
  output logic            fault,
  output logic [FC_W-1:0] fault_cnt
);

  logic            f_q, b_q, d_q, dump_q;
  state_e          state_q, state_d;
  req_e            req;
  logic            dt_start;
  logic            dt_expire;
  logic [FC_W-1:0] fault_cnt_q, fault_cnt_d;

  assign req = req_e'({f_q, b_q});

  bridge_gate_drv_dead_timer #(
    .DT_W     (DT_W),
    .DT_RESET (DT_RESET)
  ) u_dead_timer (
    .clkin    (clkin),
    .resetn   (resetn),
    .load_i   (load),
    .dtdata_i (dtdata),
    .start_i  (dt_start),
    .expire_o (dt_expire)
  );

  always_comb begin
    state_d  = state_q;
    dt_start = 1'b0;
    if (state_q != S_FAULT && req == REQ_ILL) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req == REQ_A)      state_d = S_DRV_A;
          else if (req == REQ_B) state_d = S_DRV_B;
        end
        S_DRV_A: begin
          if (req != REQ_A) begin
            state_d  = S_DEAD;
            dt_start = 1'b1;
          end
        end
        S_DRV_B: begin
          if (req != REQ_B) begin
            state_d  = S_DEAD;
            dt_start = 1'b1;
          end
        end
        S_DEAD: begin
          // Requests are only looked at on the final dead-time cycle.
          if (dt_expire) begin
            if (req == REQ_A)      state_d = S_DRV_A;
            else if (req == REQ_B) state_d = S_DRV_B;
            else                   state_d = S_IDLE;
          end
        end
        S_FAULT: begin
          if (clr_fault && req == REQ_NONE) begin
            state_d  = S_DEAD;
            dt_start = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (state_d == S_FAULT && state_q != S_FAULT && fault_cnt_q != '1) begin
      fault_cnt_d = fault_cnt_q + FC_W'(1);
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      f_q         <= 1'b0;
      b_q         <= 1'b0;
      d_q         <= 1'b0;
      dump_q      <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      f_q         <= forward;
      b_q         <= back;
      d_q         <= dumpoff_ctrl;
      dump_q      <= d_q;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  // Gates come straight from state flops so they cannot glitch.
  assign ha        = state_q[IDX_DRV_A];
  assign lb        = state_q[IDX_DRV_A];
  assign hb        = state_q[IDX_DRV_B];
  assign la        = state_q[IDX_DRV_B];
  assign fault     = state_q[IDX_FAULT];
  assign dump_gate = dump_q & ~state_q[IDX_FAULT];
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_bridge_gate_drv.sv
// Directed bench for bridge_gate_drv: per-edge expected outputs go through a scoreboard queue.
module tb_bridge_gate_drv;

  localparam int DT_W = 4;
  localparam int FC_W = 8;

  localparam logic [3:0] O_NONE = 4'b0000;
  localparam logic [3:0] O_A    = 4'b1000;
  localparam logic [3:0] O_B    = 4'b0100;
  localparam logic [3:0] O_D    = 4'b0010;
  localparam logic [3:0] O_F    = 4'b0001;

  logic            clkin = 1'b0;
  logic            resetn;
  logic            forward, back, dumpoff_ctrl, load, clr_fault;
  logic [DT_W-1:0] dtdata;
  logic            ha, lb, hb, la, dump_gate, fault;
  logic [FC_W-1:0] fault_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  bridge_gate_drv #(.DT_W(DT_W), .DT_RESET(2), .FC_W(FC_W)) dut (
    .clkin        (clkin),
    .resetn       (resetn),
    .forward      (forward),
    .back         (back),
    .dumpoff_ctrl (dumpoff_ctrl),
    .load         (load),
    .dtdata       (dtdata),
    .clr_fault    (clr_fault),
    .ha           (ha),
    .lb           (lb),
    .hb           (hb),
    .la           (la),
    .dump_gate    (dump_gate),
    .fault        (fault),
    .fault_cnt    (fault_cnt)
  );

  always #5 clkin = ~clkin;

  function automatic logic [5:0] expand(input logic [3:0] e);
    return {e[3], e[3], e[2], e[2], e[1], e[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive inputs, queue the outputs expected after the next edge, then compare.
  task automatic cyc(input logic f, input logic b, input logic d, input logic clr,
                     input logic [3:0] e, input string tag);
    logic [5:0] obs;
    logic [5:0] expv;
    string      t;
    forward = f; back = b; dumpoff_ctrl = d; clr_fault = clr;
    exp_q.push_back(expand(e));
    tag_q.push_back(tag);
    @(posedge clkin); #1;
    obs  = {ha, lb, hb, la, dump_gate, fault};
    expv = exp_q.pop_front();
    t    = tag_q.pop_front();
    check(t, 32'(obs), 32'(expv));
  endtask

  task automatic raw_edge(input logic f, input logic b, input logic clr);
    forward = f; back = b; clr_fault = clr; dumpoff_ctrl = 1'b0;
    @(posedge clkin); #1;
  endtask

  initial begin
    resetn = 1'b0; forward = 0; back = 0; dumpoff_ctrl = 0; load = 0; dtdata = '0; clr_fault = 0;
    repeat (2) @(posedge clkin);
    #1;
    check("reset_outputs", 32'({ha, lb, hb, la, dump_gate, fault}), 32'(0));
    check("reset_fcnt", 32'(fault_cnt), 32'(0));
    @(negedge clkin); resetn = 1'b1;
    @(posedge clkin); #1;

    // forward for 4 cycles, default dead time 2
    cyc(1, 0, 0, 0, O_NONE, "fwd_lat1");
    cyc(1, 0, 0, 0, O_A,    "fwd_on1");
    cyc(1, 0, 0, 0, O_A,    "fwd_on2");
    cyc(1, 0, 0, 0, O_A,    "fwd_on3");
    cyc(0, 0, 0, 0, O_A,    "fwd_on4");
    cyc(0, 0, 0, 0, O_NONE, "fwd_off");
    cyc(0, 0, 0, 0, O_NONE, "fwd_dead1");
    cyc(0, 0, 0, 0, O_NONE, "fwd_idle");

    // dead time 3, same-edge reversal
    load = 1; dtdata = 4'd3;
    cyc(1, 0, 0, 0, O_NONE, "dt3_lat");
    load = 0;
    cyc(1, 0, 0, 0, O_A,    "dt3_a1");
    cyc(1, 0, 0, 0, O_A,    "dt3_a2");
    cyc(0, 1, 0, 0, O_A,    "dt3_a3");
    cyc(0, 1, 0, 0, O_NONE, "dt3_dead1");
    cyc(0, 1, 0, 0, O_NONE, "dt3_dead2");
    cyc(0, 1, 0, 0, O_NONE, "dt3_dead3");
    cyc(0, 1, 0, 0, O_B,    "dt3_b1");
    cyc(0, 0, 0, 0, O_B,    "dt3_b2");
    cyc(0, 0, 0, 0, O_NONE, "dt3_off");
    cyc(0, 0, 0, 0, O_NONE, "dt3_tail1");
    cyc(0, 0, 0, 0, O_NONE, "dt3_tail2");

    // dead time 0 behaves as 1
    load = 1; dtdata = 4'd0;
    cyc(1, 0, 0, 0, O_NONE, "dt0_lat");
    load = 0;
    cyc(1, 0, 0, 0, O_A,    "dt0_a1");
    cyc(0, 1, 0, 0, O_A,    "dt0_a2");
    cyc(0, 1, 0, 0, O_NONE, "dt0_dead");
    cyc(0, 1, 0, 0, O_B,    "dt0_b1");
    cyc(0, 0, 0, 0, O_B,    "dt0_b2");
    cyc(0, 0, 0, 0, O_NONE, "dt0_off");
    cyc(0, 0, 0, 0, O_NONE, "dt0_idle");

    // shoot-through fault from DRV_A, clear rules
    cyc(1, 0, 0, 0, O_NONE, "flt_lat");
    cyc(1, 0, 0, 0, O_A,    "flt_a");
    cyc(1, 1, 0, 0, O_A,    "flt_a_ill");
    cyc(1, 0, 0, 0, O_F,    "flt_enter");
    check("flt_cnt1", 32'(fault_cnt), 32'(1));
    cyc(1, 0, 0, 1, O_F,    "flt_clr_ignored");
    cyc(0, 0, 0, 0, O_F,    "flt_hold");
    cyc(0, 0, 0, 1, O_NONE, "flt_clr_dead");
    cyc(0, 0, 0, 0, O_NONE, "flt_idle");
    check("flt_cnt_kept", 32'(fault_cnt), 32'(1));

    // dump gate latency and FAULT masking
    cyc(0, 0, 1, 0, O_NONE, "dmp_lat");
    cyc(0, 0, 1, 0, O_D,    "dmp_on1");
    cyc(0, 0, 0, 0, O_D,    "dmp_on2");
    cyc(0, 0, 0, 0, O_NONE, "dmp_off");
    cyc(1, 1, 1, 0, O_NONE, "dmp_ill");
    cyc(0, 0, 1, 0, O_F,    "dmp_mask1");
    cyc(0, 0, 1, 0, O_F,    "dmp_mask2");
    cyc(0, 0, 1, 1, O_D,    "dmp_unmask");
    cyc(0, 0, 0, 0, O_D,    "dmp_tail");
    cyc(0, 0, 0, 0, O_NONE, "dmp_off2");
    check("dmp_fcnt2", 32'(fault_cnt), 32'(2));

    // fault counter saturation: 256 faults total
    for (int i = 0; i < 253; i++) begin
      raw_edge(1, 1, 0);
      raw_edge(0, 0, 0);
      raw_edge(0, 0, 1);
      raw_edge(0, 0, 0);
    end
    check("sat_255", 32'(fault_cnt), 32'(255));
    raw_edge(1, 1, 0);
    raw_edge(0, 0, 0);
    check("sat_hold_fault", 32'(fault), 32'(1));
    check("sat_hold", 32'(fault_cnt), 32'(255));
    raw_edge(0, 0, 1);
    raw_edge(0, 0, 0);

    // asynchronous reset while driving B
    cyc(0, 1, 0, 0, O_NONE, "rst_b_lat");
    cyc(0, 1, 0, 0, O_B,    "rst_b_on");
    #1 resetn = 1'b0;
    #1;
    check("rst_async_gates", 32'({ha, lb, hb, la, fault}), 32'(0));
    check("rst_async_fcnt", 32'(fault_cnt), 32'(0));
    back = 0;
    @(negedge clkin); resetn = 1'b1;
    @(posedge clkin); #1;

    // dead time is back to 2 after reset
    cyc(1, 0, 0, 0, O_NONE, "post_lat");
    cyc(1, 0, 0, 0, O_A,    "post_a1");
    cyc(0, 1, 0, 0, O_A,    "post_a2");
    cyc(0, 1, 0, 0, O_NONE, "post_dead1");
    cyc(0, 1, 0, 0, O_NONE, "post_dead2");
    cyc(0, 1, 0, 0, O_B,    "post_b1");
    cyc(0, 0, 0, 0, O_B,    "post_b2");
    cyc(0, 0, 0, 0, O_NONE, "post_off");
    cyc(0, 0, 0, 0, O_NONE, "post_dead3");
    cyc(0, 0, 0, 0, O_NONE, "post_idle");

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
